// File: rtl/mips_pkg.sv
// Shared MIPS constants: instruction width, field bit positions and fetch FSM states.
package mips_pkg;
  localparam int unsigned     INSTR_W   = 32;
  localparam logic [31:0]     NOP_INSTR = 32'h0000_0000;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_MSB     = 25;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_MSB     = 20;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_MSB     = 15;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned IMM_LSB    = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: reset load, sequential increment and word-aligned redirect.
module pc_reg #(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int unsigned        PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_en_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] target_i,
  output logic [ADDR_W-1:0] pc_o
);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(3);

  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_i)    pc_d = target_i & ~ALIGN_MASK;
    else if (inc_en_i) pc_d = pc_q + ADDR_W'(PC_STEP);
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc_o = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, imem request/ack handshake, instruction register and field decode.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky 'misaligned' flag for unaligned branch targets.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int unsigned        PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branchTaken,
  input  logic [ADDR_W-1:0]  branchTarget,
  output logic               imemReq,
  output logic [ADDR_W-1:0]  imemAddr,
  input  logic               imemAck,
  input  logic [INSTR_W-1:0] imemData,
  output logic               instrValid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pcPlus4,
  output logic [5:0]         opcode,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic               misaligned,
`endif
  output logic [15:0]        offsetOut
);
  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               vld_q, vld_d;
  logic [ADDR_W-1:0]  pcp4_q, pcp4_d;
  logic [ADDR_W-1:0]  pc;
  logic               pc_inc;

  pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) u_pc (
    .clk       (clk),
    .rst       (rst),
    .inc_en_i  (pc_inc),
    .redirect_i(branchTaken),
    .target_i  (branchTarget),
    .pc_o      (pc)
  );

  // A redirect overrides everything below reset, including a same-cycle ack and stall.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    vld_d   = vld_q;
    pcp4_d  = pcp4_q;
    pc_inc  = 1'b0;
    if (branchTaken) begin
      state_d = REQ;
      vld_d   = 1'b0;
      instr_d = NOP_INSTR;
    end else begin
      unique case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (imemAck) begin
            instr_d = imemData;
            vld_d   = 1'b1;
            pcp4_d  = pc + ADDR_W'(PC_STEP);
            pc_inc  = 1'b1;
            state_d = stall ? HOLD : REQ;
          end else if (stall) begin
            state_d = HOLD;
          end
        end
        HOLD: if (!stall) state_d = REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      instr_q <= NOP_INSTR;
      vld_q   <= 1'b0;
      pcp4_q  <= RESET_PC + ADDR_W'(PC_STEP);
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      pcp4_q  <= pcp4_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned_q;
  always_ff @(posedge clk) begin
    if (rst)                                    misaligned_q <= 1'b0;
    else if (branchTaken && |branchTarget[1:0]) misaligned_q <= 1'b1;
  end
  assign misaligned = misaligned_q;
`endif

  assign imemReq    = (state_q == REQ);
  assign imemAddr   = pc;
  assign instrValid = vld_q;
  assign instr      = instr_q;
  assign pcPlus4    = pcp4_q;
  assign opcode     = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign rs         = instr_q[RS_MSB:RS_LSB];
  assign rt         = instr_q[RT_MSB:RT_LSB];
  assign rd         = instr_q[RD_MSB:RD_LSB];
  assign offsetOut  = instr_q[IMM_MSB:IMM_LSB];
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake, delayed ack, stall, branch, alignment, reset.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, stall, branchTaken, imemAck;
  logic [31:0] branchTarget, imemData;
  logic        imemReq, instrValid;
  logic [31:0] imemAddr, instr, pcPlus4;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [15:0] offsetOut;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        misaligned;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .branchTaken(branchTaken),
    .branchTarget(branchTarget), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemAck(imemAck), .imemData(imemData), .instrValid(instrValid),
    .instr(instr), .pcPlus4(pcPlus4), .opcode(opcode), .rs(rs), .rt(rt),
    .rd(rd),
`ifdef FETCH_ALIGN_CHECK_EN
    .misaligned(misaligned),
`endif
    .offsetOut(offsetOut)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; branchTaken = 1'b0; imemAck = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branchTaken = 1'b0; branchTarget = '0;
    imemAck = 1'b0; imemData = '0;
    step(2);
    chk("rst_req",   32'(imemReq), 32'd0);
    chk("rst_vld",   32'(instrValid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pcp4",  pcPlus4, 32'h4);
    chk("rst_addr",  imemAddr, 32'h0);
    rst = 1'b0;
    step(1);
    chk("idle2req", 32'(imemReq), 32'd1);

    // back-to-back acks
    chk("seq_addr0", imemAddr, 32'h0);
    imemAck = 1'b1; imemData = 32'h2001_AABB;
    step(1);
    chk("seq_addr4", imemAddr, 32'h4);
    chk("seq_off",   32'(offsetOut), 32'h0000_AABB);
    chk("seq_opc",   32'(opcode), 32'h08);
    chk("seq_rs",    32'(rs), 32'd0);
    chk("seq_rt",    32'(rt), 32'd1);
    chk("seq_pcp4",  pcPlus4, 32'h4);
    chk("seq_sext",  {{16{offsetOut[15]}}, offsetOut}, 32'hFFFF_AABB);
    imemData = 32'h8C22_1515;
    step(1);
    chk("seq_addr8", imemAddr, 32'h8);
    chk("seq_opc2",  32'(opcode), 32'h23);
    chk("seq_rt2",   32'(rt), 32'd2);
    chk("seq_rd2",   32'(rd), 32'd2);
    chk("seq_pcp4b", pcPlus4, 32'h8);
    imemAck = 1'b0;

    // ack delayed three cycles
    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk("dly_req",  32'(imemReq), 32'd1);
      chk("dly_addr", imemAddr, 32'h0);
      chk("dly_vld",  32'(instrValid), 32'd0);
      step(1);
    end
    imemAck = 1'b1; imemData = 32'h1111_2222;
    chk("dly_vld_ack", 32'(instrValid), 32'd0);
    step(1);
    imemAck = 1'b0;
    chk("dly_vld_after", 32'(instrValid), 32'd1);
    chk("dly_instr", instr, 32'h1111_2222);

    // stall with the ack, stray ack during HOLD is ignored
    do_reset();
    imemAck = 1'b1; imemData = 32'h0000_2044; stall = 1'b1;
    step(1);
    imemData = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      chk("stl_instr", instr, 32'h0000_2044);
      chk("stl_req",   32'(imemReq), 32'd0);
      chk("stl_pcp4",  pcPlus4, 32'h4);
      step(1);
    end
    imemAck = 1'b0; stall = 1'b0;
    step(1);
    chk("stl_resume_req",  32'(imemReq), 32'd1);
    chk("stl_resume_addr", imemAddr, 32'h4);
    chk("stl_instr_keep",  instr, 32'h0000_2044);

    // stall in REQ without ack
    stall = 1'b1;
    step(1);
    chk("stlna_req", 32'(imemReq), 32'd0);
    chk("stlna_addr", imemAddr, 32'h4);
    stall = 1'b0;
    step(1);

    // branch with a simultaneous ack
    branchTaken = 1'b1; branchTarget = 32'h0000_0100;
    imemAck = 1'b1; imemData = 32'hBAD0_BAD0;
    step(1);
    branchTaken = 1'b0;
    chk("br_vld",   32'(instrValid), 32'd0);
    chk("br_instr", instr, 32'h0);
    chk("br_addr",  imemAddr, 32'h100);
    imemData = 32'h0000_1234;
    step(1);
    imemAck = 1'b0;
    chk("br_pcp4",  pcPlus4, 32'h104);
    chk("br_instr2", instr, 32'h0000_1234);

    // branch wins over stall, stall applies the next cycle
    stall = 1'b1; branchTaken = 1'b1; branchTarget = 32'h0000_0200;
    step(1);
    branchTaken = 1'b0;
    chk("brstl_req",  32'(imemReq), 32'd1);
    chk("brstl_addr", imemAddr, 32'h200);
    step(1);
    chk("brstl_hold", 32'(imemReq), 32'd0);
    stall = 1'b0;
    step(1);

    // unaligned target
    branchTaken = 1'b1; branchTarget = 32'h0000_0102;
    step(1);
    branchTaken = 1'b0;
    chk("mis_addr", imemAddr, 32'h100);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_set", 32'(misaligned), 32'd1);
    step(10);
    chk("mis_sticky", 32'(misaligned), 32'd1);
    do_reset();
    chk("mis_clr", 32'(misaligned), 32'd0);
`endif

    // PC wrap
    branchTaken = 1'b1; branchTarget = 32'hFFFF_FFFC;
    step(1);
    branchTaken = 1'b0;
    imemAck = 1'b1; imemData = 32'h0000_00AA;
    step(1);
    imemAck = 1'b0;
    chk("wrap_addr", imemAddr, 32'h0);
    chk("wrap_pcp4", pcPlus4, 32'h0);

    // reset mid-handshake at pc 8
    branchTaken = 1'b1; branchTarget = 32'h0000_0008;
    step(1);
    branchTaken = 1'b0;
    chk("rmid_pre_addr", imemAddr, 32'h8);
    imemAck = 1'b1; imemData = 32'h5555_5555; rst = 1'b1;
    step(1);
    imemAck = 1'b0;
    chk("rmid_req",   32'(imemReq), 32'd0);
    chk("rmid_instr", instr, 32'h0);
    chk("rmid_vld",   32'(instrValid), 32'd0);
    chk("rmid_addr",  imemAddr, 32'h0);
    rst = 1'b0;
    step(1);
    chk("rmid_restart_req",  32'(imemReq), 32'd1);
    chk("rmid_restart_addr", imemAddr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
